// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - 8-entry in-order retirement buffer with CDB capture and mispredict flush
module reorder_buffer #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  alloc_valid_in,
    input  logic                  alloc_writes_rd_in,
    input  logic [4:0]            alloc_rd_in,
    output logic                  alloc_ready_out,
    output logic [2:0]            alloc_rob_ix_out,
    input  logic                  cdb_valid_in,
    input  logic [2:0]            cdb_rob_ix_in,
    input  logic [XLEN-1:0]       cdb_data_in,
    input  logic                  cdb_mispredict_in,
    input  logic [XLEN-1:0]       cdb_target_in,
    input  logic [2:0]            q1_rob_ix_in,
    input  logic [2:0]            q2_rob_ix_in,
    output logic                  q1_ready_out,
    output logic                  q2_ready_out,
    output logic [XLEN-1:0]       q1_data_out,
    output logic [XLEN-1:0]       q2_data_out,
    output logic                  commit_valid_out,
    output logic                  commit_we_out,
    output logic [4:0]            commit_wa_out,
    output logic [XLEN-1:0]       commit_wd_out,
    output logic [2:0]            commit_rob_ix_out,
    output logic                  flush_out,
    output logic [DEPTH-1:0][4:0] flush_addrs_out,
    output logic [XLEN-1:0]       redirect_pc_out,
    output logic                  empty_out,
    output logic                  full_out
);

    typedef enum logic {NORMAL, FLUSH} state_t;

    state_t                  state_q, state_d;
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [DEPTH-1:0]        done_q, done_d;
    logic [DEPTH-1:0]        wr_q, wr_d;
    logic [DEPTH-1:0]        mp_q, mp_d;
    logic [DEPTH-1:0][4:0]   rd_q, rd_d;
    logic [DEPTH-1:0][XLEN-1:0] data_q, data_d;
    logic [DEPTH-1:0][XLEN-1:0] target_q, target_d;
    logic [2:0]              head_q, head_d;
    logic [2:0]              tail_q, tail_d;
    logic [3:0]              count_q, count_d;
    logic [XLEN-1:0]         redirect_tgt_q, redirect_tgt_d;

    logic                    commit_valid_d, commit_we_d;
    logic [4:0]              commit_wa_d;
    logic [XLEN-1:0]         commit_wd_d;
    logic [2:0]              commit_rob_ix_d;
    logic                    flush_d;
    logic [DEPTH-1:0][4:0]   flush_addrs_d;
    logic [XLEN-1:0]         redirect_pc_d;

    logic                    alloc_fire, commit_fire;

    assign alloc_ready_out  = (state_q == NORMAL) && (count_q < 4'(DEPTH));
    assign alloc_rob_ix_out = tail_q;
    assign empty_out        = (count_q == 4'd0);
    assign full_out         = (count_q == 4'(DEPTH));
    assign alloc_fire       = alloc_valid_in && alloc_ready_out;
    assign commit_fire      = (state_q == NORMAL) && valid_q[head_q] && done_q[head_q];

    // Operand lookup: a result on the CDB this cycle is forwarded before it lands in the entry.
    function automatic logic [XLEN:0] lookup(input logic [2:0] ix);
        logic [XLEN:0] r;
        r = '0;
        if (valid_q[ix]) begin
            if ((state_q == NORMAL) && cdb_valid_in && (cdb_rob_ix_in == ix)) begin
                r = {1'b1, cdb_data_in};
            end else if (done_q[ix]) begin
                r = {1'b1, data_q[ix]};
            end
        end
        return r;
    endfunction

    always_comb begin
        {q1_ready_out, q1_data_out} = lookup(q1_rob_ix_in);
        {q2_ready_out, q2_data_out} = lookup(q2_rob_ix_in);
    end

    always_comb begin
        state_d         = state_q;
        valid_d         = valid_q;
        done_d          = done_q;
        wr_d            = wr_q;
        mp_d            = mp_q;
        rd_d            = rd_q;
        data_d          = data_q;
        target_d        = target_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        redirect_tgt_d  = redirect_tgt_q;
        commit_valid_d  = 1'b0;
        commit_we_d     = 1'b0;
        commit_wa_d     = '0;
        commit_wd_d     = '0;
        commit_rob_ix_d = '0;
        flush_d         = 1'b0;
        flush_addrs_d   = '0;
        redirect_pc_d   = '0;

        if (state_q == FLUSH) begin
            flush_d       = 1'b1;
            redirect_pc_d = redirect_tgt_q;
            for (int j = 0; j < DEPTH; j++) begin
                if (valid_q[j] && wr_q[j]) begin
                    flush_addrs_d[j] = rd_q[j];
                end
            end
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            state_d = NORMAL;
        end else begin
            if (cdb_valid_in && valid_q[cdb_rob_ix_in]) begin
                done_d[cdb_rob_ix_in]   = 1'b1;
                data_d[cdb_rob_ix_in]   = cdb_data_in;
                mp_d[cdb_rob_ix_in]     = cdb_mispredict_in;
                target_d[cdb_rob_ix_in] = cdb_target_in;
            end
            if (commit_fire) begin
                commit_valid_d  = 1'b1;
                commit_we_d     = wr_q[head_q] && (rd_q[head_q] != 5'd0);
                commit_wa_d     = rd_q[head_q];
                commit_wd_d     = data_q[head_q];
                commit_rob_ix_d = head_q;
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = head_q + 3'd1;
                // The branch itself retires normally; the flush happens in the following cycle.
                if (mp_q[head_q]) begin
                    state_d        = FLUSH;
                    redirect_tgt_d = target_q[head_q];
                end
            end
            if (alloc_fire) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                mp_d[tail_q]    = 1'b0;
                wr_d[tail_q]    = alloc_writes_rd_in;
                rd_d[tail_q]    = alloc_rd_in;
                tail_d          = tail_q + 3'd1;
            end
            count_d = count_q + {3'b0, alloc_fire} - {3'b0, commit_fire};
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q           <= NORMAL;
            valid_q           <= '0;
            done_q            <= '0;
            wr_q              <= '0;
            mp_q              <= '0;
            rd_q              <= '0;
            data_q            <= '0;
            target_q          <= '0;
            head_q            <= '0;
            tail_q            <= '0;
            count_q           <= '0;
            redirect_tgt_q    <= '0;
            commit_valid_out  <= 1'b0;
            commit_we_out     <= 1'b0;
            commit_wa_out     <= '0;
            commit_wd_out     <= '0;
            commit_rob_ix_out <= '0;
            flush_out         <= 1'b0;
            flush_addrs_out   <= '0;
            redirect_pc_out   <= '0;
        end else begin
            state_q           <= state_d;
            valid_q           <= valid_d;
            done_q            <= done_d;
            wr_q              <= wr_d;
            mp_q              <= mp_d;
            rd_q              <= rd_d;
            data_q            <= data_d;
            target_q          <= target_d;
            head_q            <= head_d;
            tail_q            <= tail_d;
            count_q           <= count_d;
            redirect_tgt_q    <= redirect_tgt_d;
            commit_valid_out  <= commit_valid_d;
            commit_we_out     <= commit_we_d;
            commit_wa_out     <= commit_wa_d;
            commit_wd_out     <= commit_wd_d;
            commit_rob_ix_out <= commit_rob_ix_d;
            flush_out         <= flush_d;
            flush_addrs_out   <= flush_addrs_d;
            redirect_pc_out   <= redirect_pc_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - scoreboard bench for reorder_buffer retirement, bypass and flush
module tb_reorder_buffer;
    localparam int XLEN = 32;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic            alloc_valid_in, alloc_writes_rd_in;
    logic [4:0]      alloc_rd_in;
    logic            alloc_ready_out;
    logic [2:0]      alloc_rob_ix_out;
    logic            cdb_valid_in, cdb_mispredict_in;
    logic [2:0]      cdb_rob_ix_in;
    logic [XLEN-1:0] cdb_data_in, cdb_target_in;
    logic [2:0]      q1_rob_ix_in, q2_rob_ix_in;
    logic            q1_ready_out, q2_ready_out;
    logic [XLEN-1:0] q1_data_out, q2_data_out;
    logic            commit_valid_out, commit_we_out;
    logic [4:0]      commit_wa_out;
    logic [XLEN-1:0] commit_wd_out;
    logic [2:0]      commit_rob_ix_out;
    logic            flush_out;
    logic [7:0][4:0] flush_addrs_out;
    logic [XLEN-1:0] redirect_pc_out;
    logic            empty_out, full_out;

    reorder_buffer #(.DEPTH(8), .XLEN(XLEN)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .alloc_valid_in(alloc_valid_in), .alloc_writes_rd_in(alloc_writes_rd_in),
        .alloc_rd_in(alloc_rd_in), .alloc_ready_out(alloc_ready_out),
        .alloc_rob_ix_out(alloc_rob_ix_out),
        .cdb_valid_in(cdb_valid_in), .cdb_rob_ix_in(cdb_rob_ix_in), .cdb_data_in(cdb_data_in),
        .cdb_mispredict_in(cdb_mispredict_in), .cdb_target_in(cdb_target_in),
        .q1_rob_ix_in(q1_rob_ix_in), .q2_rob_ix_in(q2_rob_ix_in),
        .q1_ready_out(q1_ready_out), .q2_ready_out(q2_ready_out),
        .q1_data_out(q1_data_out), .q2_data_out(q2_data_out),
        .commit_valid_out(commit_valid_out), .commit_we_out(commit_we_out),
        .commit_wa_out(commit_wa_out), .commit_wd_out(commit_wd_out),
        .commit_rob_ix_out(commit_rob_ix_out),
        .flush_out(flush_out), .flush_addrs_out(flush_addrs_out),
        .redirect_pc_out(redirect_pc_out), .empty_out(empty_out), .full_out(full_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [2:0] ix;
        logic       wr;
        logic [4:0] rd;
    } exp_t;

    int              errors = 0;
    int              checks = 0;
    int              n_commits = 0;
    exp_t            sb[$];
    exp_t            mon_e;
    logic [XLEN-1:0] m_data[8];
    logic [2:0]      m_tail;

    // Retirement scoreboard: every commit must match the oldest outstanding allocation.
    always @(negedge clk_in) begin
        if (commit_valid_out === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL commit_unexpected got ix=%0d wa=%0d, expected no commit",
                         commit_rob_ix_out, commit_wa_out);
            end else begin
                mon_e = sb.pop_front();
                n_commits++;
                if (commit_rob_ix_out !== mon_e.ix || commit_we_out !== (mon_e.wr && mon_e.rd != 5'd0) ||
                    commit_wa_out !== mon_e.rd || commit_wd_out !== m_data[mon_e.ix]) begin
                    errors++;
                    $display("FAIL commit got ix=%0d we=%0b wa=%0d wd=%h, expected ix=%0d we=%0b wa=%0d wd=%h",
                             commit_rob_ix_out, commit_we_out, commit_wa_out, commit_wd_out,
                             mon_e.ix, mon_e.wr && mon_e.rd != 5'd0, mon_e.rd, m_data[mon_e.ix]);
                end
            end
        end
    end

    task automatic idle_inputs();
        alloc_valid_in = 0; alloc_writes_rd_in = 0; alloc_rd_in = 0;
        cdb_valid_in = 0; cdb_rob_ix_in = 0; cdb_data_in = 0;
        cdb_mispredict_in = 0; cdb_target_in = 0;
        q1_rob_ix_in = 0; q2_rob_ix_in = 0;
    endtask

    task automatic do_reset();
        rst_in = 0;
        idle_inputs();
        repeat (2) @(negedge clk_in);
        rst_in = 1;
        sb.delete();
        m_tail = 0;
    endtask

    task automatic alloc(input logic wr, input logic [4:0] rd);
        exp_t e;
        checks++;
        if (alloc_ready_out !== 1'b1 || alloc_rob_ix_out !== m_tail) begin
            errors++;
            $display("FAIL alloc got ready=%0b ix=%0d, expected ready=1 ix=%0d",
                     alloc_ready_out, alloc_rob_ix_out, m_tail);
        end
        alloc_valid_in = 1; alloc_writes_rd_in = wr; alloc_rd_in = rd;
        e.ix = m_tail; e.wr = wr; e.rd = rd;
        sb.push_back(e);
        m_tail++;
        @(negedge clk_in);
        alloc_valid_in = 0;
    endtask

    task automatic cdb(input logic [2:0] ix, input logic [XLEN-1:0] d,
                       input logic mp, input logic [XLEN-1:0] tgt);
        cdb_valid_in = 1; cdb_rob_ix_in = ix; cdb_data_in = d;
        cdb_mispredict_in = mp; cdb_target_in = tgt;
        m_data[ix] = d;
        @(negedge clk_in);
        cdb_valid_in = 0; cdb_mispredict_in = 0;
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (empty_out !== 1'b1 && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        @(negedge clk_in);
        checks++;
        if (empty_out !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got empty=%0b pending=%0d, expected empty=1 pending=0",
                     name, empty_out, sb.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (empty_out !== 1'b1 || full_out !== 1'b0 || alloc_ready_out !== 1'b1 || alloc_rob_ix_out !== 3'd0) begin
            errors++;
            $display("FAIL reset_status got empty=%0b full=%0b ready=%0b ix=%0d, expected 1 0 1 0",
                     empty_out, full_out, alloc_ready_out, alloc_rob_ix_out);
        end
        checks++;
        if (commit_valid_out !== 1'b0 || commit_we_out !== 1'b0 || commit_wa_out !== 5'd0 ||
            commit_wd_out !== '0 || commit_rob_ix_out !== 3'd0) begin
            errors++;
            $display("FAIL reset_commit got valid=%0b we=%0b wa=%0d wd=%h ix=%0d, expected all 0",
                     commit_valid_out, commit_we_out, commit_wa_out, commit_wd_out, commit_rob_ix_out);
        end
        checks++;
        if (flush_out !== 1'b0 || flush_addrs_out !== '0 || redirect_pc_out !== '0) begin
            errors++;
            $display("FAIL reset_flush got flush=%0b addrs=%h pc=%h, expected all 0",
                     flush_out, flush_addrs_out, redirect_pc_out);
        end
    endtask

    task automatic test_in_order();
        int c0;
        do_reset();
        c0 = n_commits;
        alloc(1, 5); alloc(1, 6); alloc(1, 7);
        cdb(2, 32'h30, 0, 0);
        @(negedge clk_in);
        checks++;
        if (commit_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL in_order_hold got commit_valid=%0b ix=%0d, expected 0", commit_valid_out, commit_rob_ix_out);
        end
        cdb(0, 32'h10, 0, 0);
        cdb(1, 32'h20, 0, 0);
        wait_empty("in_order");
        checks++;
        if (n_commits - c0 != 3) begin
            errors++;
            $display("FAIL in_order_count got %0d commits, expected 3", n_commits - c0);
        end
    endtask

    task automatic test_full_wrap();
        int n = 0;
        do_reset();
        for (int i = 0; i < 8; i++) alloc(1, 5'(10 + i));
        checks++;
        if (full_out !== 1'b1 || alloc_ready_out !== 1'b0 || empty_out !== 1'b0) begin
            errors++;
            $display("FAIL full_status got full=%0b ready=%0b empty=%0b, expected 1 0 0",
                     full_out, alloc_ready_out, empty_out);
        end
        alloc_valid_in = 1; alloc_writes_rd_in = 1; alloc_rd_in = 31;
        @(negedge clk_in);
        alloc_valid_in = 0;
        checks++;
        if (alloc_rob_ix_out !== m_tail || full_out !== 1'b1) begin
            errors++;
            $display("FAIL full_ignore got ix=%0d full=%0b, expected ix=%0d full=1",
                     alloc_rob_ix_out, full_out, m_tail);
        end
        cdb(0, 32'h55, 0, 0);
        while (full_out === 1'b1 && n < 10) begin
            @(negedge clk_in);
            n++;
        end
        checks++;
        if (full_out !== 1'b0 || alloc_rob_ix_out !== 3'd0 || alloc_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL wrap_ready got full=%0b ix=%0d ready=%0b, expected 0 0 1",
                     full_out, alloc_rob_ix_out, alloc_ready_out);
        end
        alloc(1, 20);
        checks++;
        if (full_out !== 1'b1) begin
            errors++;
            $display("FAIL wrap_full got full=%0b, expected 1", full_out);
        end
    endtask

    task automatic test_bypass_x0();
        do_reset();
        alloc(1, 0); alloc(1, 1); alloc(1, 2); alloc(1, 3);
        cdb_valid_in = 1; cdb_rob_ix_in = 3; cdb_data_in = 32'hAB; cdb_mispredict_in = 0;
        m_data[3] = 32'hAB;
        q1_rob_ix_in = 3; q2_rob_ix_in = 2;
        #1;
        checks++;
        if (q1_ready_out !== 1'b1 || q1_data_out !== 32'hAB) begin
            errors++;
            $display("FAIL bypass_q1 got ready=%0b data=%h, expected 1 000000ab", q1_ready_out, q1_data_out);
        end
        checks++;
        if (q2_ready_out !== 1'b0 || q2_data_out !== '0) begin
            errors++;
            $display("FAIL pending_q2 got ready=%0b data=%h, expected 0 0", q2_ready_out, q2_data_out);
        end
        @(negedge clk_in);
        cdb_valid_in = 0;
        #1;
        checks++;
        if (q1_ready_out !== 1'b1 || q1_data_out !== 32'hAB) begin
            errors++;
            $display("FAIL stored_q1 got ready=%0b data=%h, expected 1 000000ab", q1_ready_out, q1_data_out);
        end
        cdb(0, 32'h11, 0, 0);
        cdb(1, 32'h22, 0, 0);
        cdb(2, 32'h33, 0, 0);
        wait_empty("bypass_x0");
        checks++;
        if (q1_ready_out !== 1'b0 || q1_data_out !== '0) begin
            errors++;
            $display("FAIL retired_q1 got ready=%0b data=%h, expected 0 0", q1_ready_out, q1_data_out);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        alloc(1, 1);
        cdb(0, 32'h1, 0, 0);
        alloc(1, 2);
        checks++;
        if (empty_out !== 1'b0 || full_out !== 1'b0 || alloc_rob_ix_out !== m_tail) begin
            errors++;
            $display("FAIL b2b_ptrs got empty=%0b full=%0b ix=%0d, expected 0 0 %0d",
                     empty_out, full_out, alloc_rob_ix_out, m_tail);
        end
        cdb(1, 32'h2, 0, 0);
        wait_empty("b2b");
    endtask

    task automatic test_mispredict();
        logic [7:0][4:0] exp_fa;
        exp_fa = '0;
        exp_fa[1] = 5'd8;
        exp_fa[2] = 5'd9;
        do_reset();
        alloc(0, 0); alloc(1, 8); alloc(1, 9);
        cdb(0, 32'h0, 1, 32'h100);
        @(negedge clk_in);
        checks++;
        if (commit_valid_out !== 1'b1 || commit_we_out !== 1'b0 || flush_out !== 1'b0) begin
            errors++;
            $display("FAIL mp_commit got valid=%0b we=%0b flush=%0b, expected 1 0 0",
                     commit_valid_out, commit_we_out, flush_out);
        end
        @(negedge clk_in);
        checks++;
        if (flush_out !== 1'b1 || flush_addrs_out !== exp_fa || redirect_pc_out !== 32'h100) begin
            errors++;
            $display("FAIL mp_flush got flush=%0b addrs=%h pc=%h, expected 1 %h 00000100",
                     flush_out, flush_addrs_out, redirect_pc_out, exp_fa);
        end
        checks++;
        if (empty_out !== 1'b1 || alloc_rob_ix_out !== 3'd0 || commit_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL mp_after got empty=%0b ix=%0d commit=%0b, expected 1 0 0",
                     empty_out, alloc_rob_ix_out, commit_valid_out);
        end
        sb.delete();
        m_tail = 0;
        @(negedge clk_in);
        checks++;
        if (flush_out !== 1'b0 || redirect_pc_out !== '0 || empty_out !== 1'b1 || alloc_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL mp_pulse got flush=%0b pc=%h empty=%0b ready=%0b, expected 0 0 1 1",
                     flush_out, redirect_pc_out, empty_out, alloc_ready_out);
        end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        alloc(1, 4);
        cdb(0, 32'h5, 1, 32'h200);
        @(negedge clk_in);
        rst_in = 0;
        @(negedge clk_in);
        checks++;
        if (flush_out !== 1'b0 || empty_out !== 1'b1 || redirect_pc_out !== '0 || commit_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_flush got flush=%0b empty=%0b pc=%h commit=%0b, expected 0 1 0 0",
                     flush_out, empty_out, redirect_pc_out, commit_valid_out);
        end
        rst_in = 1;
        sb.delete();
        m_tail = 0;
        @(negedge clk_in);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 0;
        idle_inputs();
        for (int i = 0; i < 8; i++) m_data[i] = '0;
        m_tail = 0;
        test_reset();
        test_in_order();
        test_full_wrap();
        test_bypass_x0();
        test_back_to_back();
        test_mispredict();
        test_reset_mid_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- 8-entry circular reorder buffer between issue/CDB and the architectural register file.
- Allocates a ROB index per issued instruction and captures results broadcast on the CDB.
- Retires entries strictly in program order, driving the register file's write port (we/wa/wd).
- On a retiring mispredicted branch, drives the register file's flush port and a redirect PC.

Parameters:
- DEPTH, 8, number of entries; fixed at 8 to match the 3-bit ROB index.
- XLEN, 32, data and PC width.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  synchronous, active-low reset.
- alloc_valid_in  input  1  issue requests an entry this cycle.
- alloc_writes_rd_in  input  1  instruction writes a destination register.
- alloc_rd_in  input  5  destination register.
- alloc_ready_out  output  1  entry can be allocated this cycle.
- alloc_rob_ix_out  output  3  index granted; equals the tail pointer.
- cdb_valid_in  input  1  result broadcast valid.
- cdb_rob_ix_in  input  3  entry completing.
- cdb_data_in  input  XLEN  result value.
- cdb_mispredict_in  input  1  completing branch was mispredicted.
- cdb_target_in  input  XLEN  correct next PC for a mispredicted branch.
- q1_rob_ix_in, q2_rob_ix_in  input  3  operand lookup indices.
- q1_ready_out, q2_ready_out  output  1  queried entry holds its result.
- q1_data_out, q2_data_out  output  XLEN  queried result.
- commit_valid_out  output  1  head entry retired this cycle.
- commit_we_out  output  1  register-file write enable.
- commit_wa_out  output  5  register-file write address.
- commit_wd_out  output  XLEN  register-file write data.
- commit_rob_ix_out  output  3  index retired.
- flush_out  output  1  one-cycle flush pulse.
- flush_addrs_out  output  5 x 8  rd of each flushed entry; 0 for unused slots.
- redirect_pc_out  output  XLEN  fetch redirect target; valid while flush_out is high.
- empty_out, full_out  output  1  occupancy status.

Behaviour:
- State: per-entry valid, done, writes_rd, rd, data, mispredict, target. Pointers: head, tail (3 bits, wrap 7->0), count (4 bits, 0..8).
- Reset (rst_in=0 at clock edge):
  - All entries invalid; head=tail=count=0; FSM to NORMAL.
  - All commit/flush outputs 0; redirect_pc_out=0.
  - Overrides any in-flight operation, including a pending FLUSH.
- alloc_ready_out = (state==NORMAL) && (count<8). It does not count a same-cycle commit.
- Allocation on alloc_valid_in && alloc_ready_out:
  - Entry[tail] gets valid=1, done=0, rd/writes_rd from inputs; tail++.
  - alloc_valid_in while not ready is ignored; issue must hold and retry.
- CDB:
  - If cdb_valid_in and entry[cdb_rob_ix_in] is valid, set done=1 and capture data, mispredict and target.
  - A CDB write to an invalid entry is ignored.
- Query ports (combinational):
  - ready = entry done, OR a same-cycle CDB write to that index (bypass; data taken from cdb_data_in).
  - Invalid entry: ready=0, data=0.
- Commit (registered outputs, NORMAL only):
  - Fires when entry[head] is valid && done.
  - Next cycle: commit_valid_out=1, commit_we_out=writes_rd && (rd!=0), wa=rd, wd=data, rob_ix=head.
  - Entry cleared; head++.
  - At most one commit per cycle.
  - A CDB completion of the head entry commits no earlier than the following cycle (one-cycle done-to-commit latency, two cycles to the outputs).
- Simultaneous alloc and commit: count unchanged; both pointers advance.
- Mispredict handling (FSM NORMAL -> FLUSH -> NORMAL):
  - When the committing head entry has mispredict=1, the entry commits normally (its rd write is issued this cycle), then FSM enters FLUSH.
  - In FLUSH, for exactly one cycle:
    - flush_out=1.
    - flush_addrs_out[j] = rd of physical entry j if that entry is valid && writes_rd, else 0.
    - redirect_pc_out = the branch target.
    - All entries invalidated; head=tail=count=0; no commit; allocation blocked; CDB ignored.
  - Then back to NORMAL.
- Full: count==8 -> full_out=1, alloc_ready_out=0. Empty: count==0 -> empty_out=1, no commit.

Test Plan:
- Reset: hold rst_in=0 for 2 cycles -> empty_out=1, alloc_ready_out=1, alloc_rob_ix_out=0, all commit/flush outputs 0.
- In-order commit:
  - Allocate rd=5,6,7 (ix 0,1,2); CDB completes ix2=0x30, then ix0=0x10, then ix1=0x20.
  - Expected: commits in order ix0 (wa=5, wd=0x10), ix1 (wa=6, 0x20), ix2 (wa=7, 0x30), never ix2 first.
- Full and wrap:
  - Allocate 8 entries -> full_out=1, 9th request ignored.
  - Complete and commit ix0, then allocate -> alloc_rob_ix_out=0 (wrap), count=8.
- Bypass and x0:
  - CDB ix3=0xAB in the same cycle as q1_rob_ix_in=3 -> q1_ready_out=1, q1_data_out=0xAB.
  - An entry with rd=0 commits with commit_we_out=0 and commit_valid_out=1.
- Mispredict flush:
  - Entries ix0 branch (no rd), ix1 rd=8, ix2 rd=9; CDB ix0 mispredict, target 0x100.
  - Expected: ix0 commits with commit_we_out=0.
  - Next cycle: flush_out=1, flush_addrs_out[1]=8, [2]=9, others 0, redirect_pc_out=0x100.
  - Then empty_out=1 with alloc_rob_ix_out=0.
- Reset mid-flush: assert rst_in=0 during the FLUSH cycle -> next cycle flush_out=0, empty_out=1.
